// File: rtl/tdc_pkg.sv
// Shared constants and helpers for the carry-chain TDC: popcount grouping,
// fine-count width derivation, the bubble-filter majority vote and the carry cell.
package tdc_pkg;

  localparam int GROUP_W = 8;
  localparam int PSUM_W  = 4;

  function automatic int cntWidth(input int taps);
    return $clog2(taps) + 1;
  endfunction

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Behavioural SB_CARRY: CO = I0&I1 | CI&(I0|I1); with I0=0, I1=1 it forwards CI.
  function automatic logic sbCarry(input logic ci, input logic i0, input logic i1);
    return (i0 & i1) | (ci & (i0 | i1));
  endfunction

endpackage

// File: rtl/tdc_delay_line_pipe_popcount.sv
// Two-stage pipelined popcount of the filtered thermometer code; the output
// registers only load when a valid sample reaches them and hold otherwise.
module therm_popcount
  import tdc_pkg::*;
#(
  parameter int TAPS  = 64,
  parameter int CNT_W = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inValid_i,
  input  logic [TAPS-1:0]  therm_i,
  output logic [CNT_W-1:0] count_o,
  output logic             outValid_o,
  output logic             overflow_o,
  output logic             underflow_o
);

  localparam int GROUPS = TAPS / GROUP_W;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(TAPS);

  logic [PSUM_W-1:0] psum_d [GROUPS];
  logic [PSUM_W-1:0] psum_q [GROUPS];
  logic              vldA_q;
  logic [CNT_W-1:0]  sum_d;
  logic [CNT_W-1:0]  count_q;
  logic              outValid_q;
  logic              overflow_q;
  logic              underflow_q;

  always_comb begin
    for (int g = 0; g < GROUPS; g++) begin
      psum_d[g] = '0;
      for (int b = 0; b < GROUP_W; b++) begin
        psum_d[g] = psum_d[g] + PSUM_W'(therm_i[g*GROUP_W + b]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int g = 0; g < GROUPS; g++) psum_q[g] <= '0;
      vldA_q <= 1'b0;
    end else begin
      psum_q <= psum_d;
      vldA_q <= inValid_i;
    end
  end

  always_comb begin
    sum_d = '0;
    for (int g = 0; g < GROUPS; g++) begin
      sum_d = sum_d + CNT_W'(psum_q[g]);
    end
  end

  // Result and flags move together so they always describe the same sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q     <= '0;
      outValid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      outValid_q <= vldA_q;
      if (vldA_q) begin
        count_q     <= sum_d;
        overflow_q  <= (sum_d == FULL);
        underflow_q <= (sum_d == '0);
      end
    end
  end

  assign count_o     = count_q;
  assign outValid_o  = outValid_q;
  assign overflow_o  = overflow_q;
  assign underflow_o = underflow_q;

endmodule

// File: rtl/tdc_delay_line_pipe.sv
// Carry-chain delay line with synchronised capture, polarity select, optional
// bubble filter and pipelined popcount producing the TDC fine code.
module tdc_delay_line_pipe
  import tdc_pkg::*;
#(
  parameter int TAPS          = 64,
  parameter int SYNC_STAGES   = 2,
  parameter int BUBBLE_FILTER = 1,
  parameter int CNT_W         = cntWidth(TAPS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             signal_in,
  input  logic             sample,
  input  logic             edge_sel,
  input  logic             test_en,
  input  logic [TAPS-1:0]  test_taps,
  output logic [CNT_W-1:0] fine_count,
  output logic             valid,
  output logic             overflow,
  output logic             underflow
);

  logic [TAPS-1:0] taps;

  // Each stage is its own net so the chain never looks like a combinational loop.
  for (genvar i = 0; i < TAPS; i++) begin : gChain
    logic co;
    if (i == 0) begin : gFirst
      assign co = sbCarry(signal_in, 1'b0, 1'b1);
    end else begin : gNext
      assign co = sbCarry(gChain[i-1].co, 1'b0, 1'b1);
    end
    assign taps[i] = co;
  end

  logic [TAPS-1:0]        syncPipe_q [SYNC_STAGES];
  logic [SYNC_STAGES-1:0] vldPipe_q;
  logic [SYNC_STAGES-1:0] edgePipe_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) syncPipe_q[s] <= '0;
      vldPipe_q  <= '0;
      edgePipe_q <= '0;
    end else begin
      if (sample) syncPipe_q[0] <= test_en ? test_taps : taps;
      for (int s = 1; s < SYNC_STAGES; s++) syncPipe_q[s] <= syncPipe_q[s-1];
      vldPipe_q  <= {vldPipe_q[SYNC_STAGES-2:0], sample};
      edgePipe_q <= {edgePipe_q[SYNC_STAGES-2:0], edge_sel};
    end
  end

  logic [TAPS-1:0] pol;
  logic [TAPS-1:0] filt_d;
  logic [TAPS-1:0] filt_q;
  logic            filtVld_q;

  assign pol = edgePipe_q[SYNC_STAGES-1] ? ~syncPipe_q[SYNC_STAGES-1]
                                         : syncPipe_q[SYNC_STAGES-1];

  // Virtual taps below the chain read as 1 and above it as 0.
  if (BUBBLE_FILTER != 0) begin : gFilter
    logic [TAPS+1:0] ext;
    assign ext = {1'b0, pol, 1'b1};
    for (genvar i = 0; i < TAPS; i++) begin : gBit
      assign filt_d[i] = maj3(ext[i], ext[i+1], ext[i+2]);
    end
  end else begin : gBypass
    assign filt_d = pol;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      filt_q    <= '0;
      filtVld_q <= 1'b0;
    end else begin
      filt_q    <= filt_d;
      filtVld_q <= vldPipe_q[SYNC_STAGES-1];
    end
  end

  therm_popcount #(
    .TAPS  (TAPS),
    .CNT_W (CNT_W)
  ) uPopcount (
    .clk         (clk),
    .rst         (rst),
    .inValid_i   (filtVld_q),
    .therm_i     (filt_q),
    .count_o     (fine_count),
    .outValid_o  (valid),
    .overflow_o  (overflow),
    .underflow_o (underflow)
  );

endmodule

// File: tb/tb_tdc_delay_line_pipe.sv
// Scoreboard bench: two DUTs (bubble filter on and off) share stimulus; a
// reference model queues expected codes and a negedge monitor checks them.
module tb_tdc_delay_line_pipe;

  typedef struct {
    int count;
    bit ovf;
    bit unf;
    int issue;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        signal_in = 1'b0;
  logic        sample = 1'b0;
  logic        edge_sel = 1'b0;
  logic        test_en = 1'b1;
  logic [63:0] test_taps = '0;

  logic [6:0]  countF, countR;
  logic        validF, validR, ovfF, ovfR, unfF, unfR;

  exp_t expF[$];
  exp_t expR[$];
  exp_t lastF = '{count: 0, ovf: 1'b0, unf: 1'b0, issue: 0};
  exp_t lastR = '{count: 0, ovf: 1'b0, unf: 1'b0, issue: 0};
  exp_t e;

  int  nCompared = 0;
  int  nMismatch = 0;
  int  cycleCount = 0;
  bit  monEn = 1'b0;

  tdc_delay_line_pipe #(.TAPS(64), .SYNC_STAGES(2), .BUBBLE_FILTER(1)) dutF (
    .clk(clk), .rst(rst), .signal_in(signal_in), .sample(sample),
    .edge_sel(edge_sel), .test_en(test_en), .test_taps(test_taps),
    .fine_count(countF), .valid(validF), .overflow(ovfF), .underflow(unfF)
  );

  tdc_delay_line_pipe #(.TAPS(64), .SYNC_STAGES(2), .BUBBLE_FILTER(0)) dutR (
    .clk(clk), .rst(rst), .signal_in(signal_in), .sample(sample),
    .edge_sel(edge_sel), .test_en(test_en), .test_taps(test_taps),
    .fine_count(countR), .valid(validR), .overflow(ovfR), .underflow(unfR)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCount++;

  // Reference: invert for falling edges, majority vote with fixed boundaries, count ones.
  function automatic exp_t model(input logic [63:0] src, input logic es,
                                 input bit filt, input int issue);
    logic [63:0] t;
    bit lo, hi, b;
    int n;
    exp_t r;
    t = es ? ~src : src;
    n = 0;
    for (int i = 0; i < 64; i++) begin
      lo = (i == 0)  ? 1'b1 : t[i-1];
      hi = (i == 63) ? 1'b0 : t[i+1];
      b  = filt ? ((int'(lo) + int'(t[i]) + int'(hi)) >= 2) : t[i];
      n += int'(b);
    end
    r.count = n;
    r.ovf   = (n == 64);
    r.unf   = (n == 0);
    r.issue = issue;
    return r;
  endfunction

  function automatic logic [63:0] therm(input int n);
    logic [63:0] one;
    one = 64'd1;
    return (n >= 64) ? '1 : ((one << n) - 64'd1);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatch++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic te, input logic es,
                               input logic si, input logic [63:0] pat);
    logic [63:0] src;
    sample    = s;
    test_en   = te;
    edge_sel  = es;
    signal_in = si;
    test_taps = pat;
    if (s && !rst) begin
      src = te ? pat : {64{si}};
      expF.push_back(model(src, es, 1'b1, cycleCount));
      expR.push_back(model(src, es, 1'b0, cycleCount));
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    sample = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulseReset(input int n, input logic withSample);
    rst       = 1'b1;
    sample    = withSample;
    test_en   = 1'b1;
    test_taps = '1;
    @(posedge clk); #1;
    sample = 1'b0;
    repeat (n - 1) begin @(posedge clk); #1; end
    rst = 1'b0;
  endtask

  // Monitor: pop on valid, otherwise outputs must hold the last result.
  always @(negedge clk) begin
    if (monEn) begin
      if (validF) begin
        if (expF.size() == 0) checkOutput("filt unexpected valid", 1, 0);
        else begin
          e = expF.pop_front();
          checkOutput("filt fine_count", countF, e.count);
          checkOutput("filt overflow", ovfF, e.ovf);
          checkOutput("filt underflow", unfF, e.unf);
          checkOutput("filt latency", cycleCount - e.issue, 5);
          lastF = e;
        end
      end else begin
        checkOutput("filt hold fine_count", countF, lastF.count);
        checkOutput("filt hold flags", {ovfF, unfF}, {lastF.ovf, lastF.unf});
      end
      if (validR) begin
        if (expR.size() == 0) checkOutput("raw unexpected valid", 1, 0);
        else begin
          e = expR.pop_front();
          checkOutput("raw fine_count", countR, e.count);
          checkOutput("raw overflow", ovfR, e.ovf);
          checkOutput("raw underflow", unfR, e.unf);
          checkOutput("raw latency", cycleCount - e.issue, 5);
          lastR = e;
        end
      end else begin
        checkOutput("raw hold fine_count", countR, lastR.count);
        checkOutput("raw hold flags", {ovfR, unfR}, {lastR.ovf, lastR.unf});
      end
      if (rst) begin
        expF.delete();
        expR.delete();
        lastF = '{count: 0, ovf: 1'b0, unf: 1'b0, issue: 0};
        lastR = '{count: 0, ovf: 1'b0, unf: 1'b0, issue: 0};
      end
    end
  end

  initial begin
    int kind, n, gap;
    logic [63:0] pat;
    rst = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    checkOutput("reset fine_count", countF, 0);
    checkOutput("reset valid", validF, 0);
    checkOutput("reset flags", {ovfF, unfF}, 0);
    rst   = 1'b0;
    monEn = 1'b1;
    idle(2);

    applyStimulus(1, 1, 0, 0, 64'h0000_0000_000F_FFFF); idle(7);
    applyStimulus(1, 1, 1, 0, 64'h0000_0000_000F_FFFF); idle(7);
    applyStimulus(1, 1, 0, 0, '1);                      idle(7);
    applyStimulus(1, 1, 0, 0, '0);                      idle(7);
    applyStimulus(1, 1, 0, 0, 64'h0000_0000_0000_FEFF); idle(7);
    applyStimulus(1, 1, 0, 0, therm(4));
    applyStimulus(1, 1, 0, 0, therm(9));
    applyStimulus(1, 1, 0, 0, therm(60));
    idle(10);
    applyStimulus(1, 0, 0, 1, '0); idle(7);
    applyStimulus(1, 0, 0, 0, '1); idle(7);

    applyStimulus(1, 1, 0, 0, therm(33));
    idle(1);
    pulseReset(2, 1'b0);
    idle(8);
    pulseReset(2, 1'b1);
    idle(8);
    applyStimulus(1, 1, 0, 0, therm(17)); idle(7);

    for (int k = 0; k < 400; k++) begin
      kind = $urandom_range(0, 3);
      n    = $urandom_range(0, 64);
      pat  = therm(n);
      if (kind == 1) pat[$urandom_range(0, 63)] ^= 1'b1;
      if (kind == 2) pat = {$urandom, $urandom};
      if (kind == 3) pat = ~pat;
      applyStimulus(1, ($urandom_range(0, 7) != 0), $urandom_range(0, 1),
                    $urandom_range(0, 1), pat);
      gap = $urandom_range(0, 3);
      if (gap > 0) idle(gap);
      if ($urandom_range(0, 59) == 0) pulseReset($urandom_range(1, 2), $urandom_range(0, 1));
    end

    idle(1);
    for (int i = 0; i < 50 && (expF.size() != 0 || expR.size() != 0); i++) idle(1);
    checkOutput("filt drain pending", expF.size(), 0);
    checkOutput("raw drain pending", expR.size(), 0);
    idle(2);
    monEn = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule

// File: doc/tdc_delay_line_pipe.md
Name: tdc_delay_line_pipe

Overview:
Parametrised successor to the 32-tap carry-chain delay line. It builds a TAPS-deep SB_CARRY chain and captures it through a configurable synchroniser. A bubble filter and a pipelined popcount encoder follow, producing the fine interpolation code for the TDC coarse counter. It adds edge-polarity select, overflow/underflow flags, a test-pattern injection path and a fixed-latency valid pipeline that accepts one sample per clock.

Parameters:
TAPS, 64, delay-line length; power of two, 8..128.
SYNC_STAGES, 2, register stages on captured taps (first stage is the capture flop); 2..3.
BUBBLE_FILTER, 1, 1 = 3-tap majority filter on thermometer code; 0 = bypass (stage kept as plain register).
CNT_W, $clog2(TAPS)+1, fine_count width; holds 0..TAPS inclusive. Derived; not overridden.

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
signal_in  in  1  hit signal entering carry chain tap 0
sample  in  1  capture strobe; one capture per high cycle
edge_sel  in  1  0 = rising edge (count 1s), 1 = falling edge (count 0s)
test_en  in  1  1 = replace chain taps with test_taps at capture
test_taps  in  TAPS  injected thermometer pattern
fine_count  out  CNT_W  encoded tap position
valid  out  1  one-cycle strobe; fine_count/flags valid
overflow  out  1  code == TAPS (edge passed whole chain)
underflow  out  1  code == 0 (edge not yet entered)

Behaviour:
- Chain: carry[0]=signal_in; SB_CARRY per stage with I0=0, I1=1; taps[i]=carry[i+1].
- Capture (stage S1): on sample=1, raw <= test_en ? test_taps : taps. edge_sel and sample enter sideband shift regs alongside the data.
- Sync: SYNC_STAGES-1 further unconditional register stages on the captured vector.
- Polarity: t = edge_sel_d ? ~v : v, using edge_sel delayed with its sample.
- Bubble filter stage: f[i] = maj(t[i-1], t[i], t[i+1]). Boundary: t[-1]=1, t[TAPS]=0. Registered.
- Popcount stage A: sum of each 8-bit group, registered (TAPS/8 partial sums, 4 bits each).
- Popcount stage B: add partial sums -> fine_count. overflow = (sum==TAPS); underflow = (sum==0). All registered together.
- Latency: valid rises exactly SYNC_STAGES+3 cycles after the cycle sample was high (5 at defaults). Throughput is 1 per clock. Back-to-back samples give back-to-back valids in order.
- Holding: fine_count/overflow/underflow update only when valid asserts and hold otherwise. valid is high for exactly one cycle per sample.
- Non-thermometer input with BUBBLE_FILTER=0: output is the raw popcount (no error flag).
- Sample with test_en toggling: the test_en value in the sample cycle decides the source.
- Reset: all pipeline data and sideband regs cleared. fine_count=0, valid=0, overflow=0, underflow=0 on the cycle after rst. Samples in flight are discarded (no valid emitted). A sample coinciding with rst is ignored.
- No async logic. signal_in is not synchronised beyond the capture stages.

Decomposition:
- Package tdc_pkg: localparam for group size 8, function for CNT_W, and the majority function used by the bubble filter.
- Sub-module therm_popcount (params TAPS, CNT_W): the two-stage pipelined popcount plus overflow/underflow flags, with an in_valid/out_valid sideband.
- Carry chain and bubble filter stay as generate blocks in the top.

Test Plan:
- TAPS=64, test_en=1, test_taps=64'h0000_0000_000F_FFFF, edge_sel=0, sample 1 cycle -> 5 cycles later valid=1 for 1 cycle, fine_count=20, flags 0.
- Same pattern, edge_sel=1 -> fine_count=44.
- test_taps=all 1s -> fine_count=64, overflow=1. test_taps=0 -> fine_count=0, underflow=1.
- Bubble: test_taps=64'h0000_0000_0000_FEFF (bit 8 cleared), BUBBLE_FILTER=1 -> fine_count=16. With BUBBLE_FILTER=0 -> 15.
- Samples on 3 consecutive cycles with patterns of 4, 9, 60 ones -> valid high 3 consecutive cycles, outputs 4, 9, 60 in order, fine_count held at 60 afterwards.
- Sample, then rst pulsed 2 cycles later -> no valid ever emitted, all outputs 0. Sample issued after rst deasserts -> normal 5-cycle result.
